// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared definitions for the memory responder: control FSM state encoding
//   and default geometry / write-protect constants.
package mem_responder_pkg;

    localparam int unsigned    DEF_SIZE     = 8;
    localparam int unsigned    DEF_ADDR_W   = 6;
    localparam logic [5:0]     DEF_WP_LIMIT = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

endpackage

// File: rtl/mem_array.sv
// mem_array
//   2**AddrW x Size storage, one synchronous write port and one asynchronous
//   read port. A read of the address being written returns the old value
//   until the write edge.
// Ports:
//   clk           clock, write on posedge
//   we/waddr/wdata write port
//   raddr/rdata   combinational read port
module mem_array #(
    parameter int unsigned Size  = 8,
    parameter int unsigned AddrW = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [Size-1:0]  wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [Size-1:0]  rdata
);

    logic [Size-1:0] mem [2**AddrW];

    // NOTE: the storage array has no reset; its contents must survive clr so
    // a partial load stays visible, and an un-reset array maps onto RAM cells.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the 8-bit processor bus plus a boot loader.
//   The loader fills the RAM over a valid/ready byte stream while holding the
//   processor in reset (cpu_rst_n=0), then releases it (RUN state).
//   Optional feature macro: MEM_RESPONDER_WP_EN -- when defined, RUN-state
//   CPU writes below WP_LIMIT are suppressed and flag wp_err.
// Ports:
//   clk, clr                     clock, synchronous active-high reset
//   cpu_addr/cpu_we/cpu_wdata    processor memory request
//   cpu_rdata                    combinational read data
//   cpu_rst_n                    active-low processor reset (1 only in RUN)
//   ld_start                     pulse: begin a load
//   ld_valid/ld_data/ld_last     loader byte stream
//   ld_ready, ld_busy            high only while loading
//   ld_done                      sticky: last load completed
//   ld_count                     bytes written by current/last load
//   wp_err                       sticky write-protect violation
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned      Size     = DEF_SIZE,
    parameter int unsigned      AddrW    = DEF_ADDR_W,
    parameter logic [AddrW-1:0] WP_LIMIT = DEF_WP_LIMIT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [AddrW-1:0] cpu_addr,
    input  logic             cpu_we,
    input  logic [Size-1:0]  cpu_wdata,
    output logic [Size-1:0]  cpu_rdata,
    output logic             cpu_rst_n,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic [Size-1:0]  ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             ld_busy,
    output logic             ld_done,
    output logic [AddrW:0]   ld_count,
    output logic             wp_err
);

`ifdef MEM_RESPONDER_WP_EN
    localparam bit WpEn = 1'b1;
`else
    localparam bit WpEn = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [AddrW-1:0] ptr;
    logic             accept, final_byte, enter_load;
    logic             cpu_wr, wp_block, mem_we;
    logic [AddrW-1:0] mem_waddr;
    logic [Size-1:0]  mem_wdata;

    assign accept     = ld_valid && ld_ready;
    // The pointer stops at the top address: that byte ends the load.
    assign final_byte = ld_last || (&ptr);
    assign enter_load = ld_start && (state_q != ST_LOAD);
    assign cpu_wr     = cpu_we && (state_q == ST_RUN);
    assign wp_block   = WpEn && (cpu_addr < WP_LIMIT);

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ld_start)              state_d = ST_LOAD;
            ST_LOAD: if (accept && final_byte)  state_d = ST_RUN;
            ST_RUN:  if (ld_start)              state_d = ST_LOAD;
            default:                            state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            cpu_rst_n <= 1'b0;
            ld_ready  <= 1'b0;
            ld_busy   <= 1'b0;
            ld_done   <= 1'b0;
            ld_count  <= '0;
            ptr       <= '0;
            wp_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpu_rst_n <= (state_d == ST_RUN);
            ld_ready  <= (state_d == ST_LOAD);
            ld_busy   <= (state_d == ST_LOAD);
            if (enter_load) begin
                ptr      <= '0;
                ld_count <= '0;
                ld_done  <= 1'b0;
                wp_err   <= 1'b0;
            end else begin
                if (accept) begin
                    if (!(&ptr)) ptr <= ptr + AddrW'(1);
                    ld_count <= ld_count + (AddrW+1)'(1);
                    if (final_byte) ld_done <= 1'b1;
                end
                if (cpu_wr && wp_block) wp_err <= 1'b1;
            end
        end
    end

    // Loader and CPU writes are mutually exclusive by state; loader has the
    // mux priority anyway.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cpu_addr;
        mem_wdata = cpu_wdata;
        if (accept) begin
            mem_we    = 1'b1;
            mem_waddr = ptr;
            mem_wdata = ld_data;
        end else if (cpu_wr && !wp_block) begin
            mem_we    = 1'b1;
        end
    end

    mem_array #(
        .Size  (Size),
        .AddrW (AddrW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (cpu_addr),
        .rdata (cpu_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Self-checking bench for mem_responder. Loader bytes are pushed into a
//   scoreboard queue as they are accepted and drained by CPU reads.
//   Expectations for the write-protect case follow MEM_RESPONDER_WP_EN.
module tb_mem_responder;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] data;
    } sb_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [5:0] cpu_addr = '0;
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_wdata = '0;
    logic [7:0] cpu_rdata;
    logic       cpu_rst_n;
    logic       ld_start = 1'b0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = '0;
    logic       ld_last = 1'b0;
    logic       ld_ready, ld_busy, ld_done, wp_err;
    logic [6:0] ld_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    sb_t  sb[$];
    logic [7:0] exp_mem [64];
    int   ptr_model;

    mem_responder dut (
        .clk       (clk),
        .clr       (clr),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_rst_n (cpu_rst_n),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .ld_busy   (ld_busy),
        .ld_done   (ld_done),
        .ld_count  (ld_count),
        .wp_err    (wp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ptr_model = 0;
    endtask

    // Present one byte for one edge; reports whether it was accepted.
    task automatic send(input logic [7:0] d, input logic last, output logic acc);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        acc      = ld_ready;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (acc) begin
            sb.push_back('{addr: 6'(ptr_model), data: d});
            exp_mem[ptr_model] = d;
            ptr_model++;
        end
    endtask

    task automatic drain(input string tag);
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cpu_addr = e.addr;
            #1;
            check(tag, cpu_rdata, exp_mem[e.addr]);
            check({tag, "_sb"}, cpu_rdata, e.data);
        end
        tick();
    endtask

    // CPU write; checks old data during the write cycle and result after.
    task automatic cpu_write(input string tag, input logic [5:0] a, input logic [7:0] d,
                             input logic lands);
        logic [7:0] old;
        old       = exp_mem[a];
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        #1;
        check({tag, "_old"}, cpu_rdata, old);
        tick();
        cpu_we = 1'b0;
        if (lands) exp_mem[a] = d;
        #1;
        check({tag, "_new"}, cpu_rdata, exp_mem[a]);
        tick();
    endtask

    initial begin
        logic       acc;
        logic [7:0] bytes4 [4];
        logic [7:0] v;
        bytes4[0] = 8'h11; bytes4[1] = 8'h22; bytes4[2] = 8'h33; bytes4[3] = 8'h44;
        ptr_model = 0;

        // Reset state
        tick();
        do_clr();
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_ld_ready",  ld_ready, 0);
        check("rst_ld_busy",   ld_busy, 0);
        check("rst_ld_done",   ld_done, 0);
        check("rst_ld_count",  ld_count, 0);
        check("rst_wp_err",    wp_err, 0);

        // Basic load
        start();
        check("start_ready", ld_ready, 1);
        check("start_busy",  ld_busy, 1);
        check("start_rst_n", cpu_rst_n, 0);
        for (int i = 0; i < 4; i++) begin
            send(bytes4[i], i == 3, acc);
            check("basic_acc", acc, 1);
            if (i == 2) check("basic_rst_n_pre", cpu_rst_n, 0);
        end
        check("basic_rst_n",  cpu_rst_n, 1);
        check("basic_done",   ld_done, 1);
        check("basic_count",  ld_count, 4);
        check("basic_ready",  ld_ready, 0);
        drain("basic_rd");

        // Backpressure and full load: 70 bytes, no ld_last
        start();
        for (int i = 0; i < 70; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            v = 8'(i * 7 + 3);
            send(v, 1'b0, acc);
            check("full_acc", acc, (i < 64) ? 1 : 0);
            if (i == 63) check("full_rst_n", cpu_rst_n, 1);
        end
        check("full_count", ld_count, 64);
        check("full_done",  ld_done, 1);
        check("full_busy",  ld_busy, 0);
        drain("full_rd");

        // CPU access in RUN
        cpu_write("cpu40", 6'd40, 8'hA5, 1'b1);
        check("cpu_wp_err0", wp_err, 0);

        // Write protect boundary
`ifdef MEM_RESPONDER_WP_EN
        cpu_write("wp5", 6'd5, 8'hFF, 1'b0);
        check("wp5_err", wp_err, 1);
        cpu_write("wp31", 6'd31, 8'h5C, 1'b0);
        cpu_write("wp32", 6'd32, 8'hC3, 1'b1);
`else
        cpu_write("wp5", 6'd5, 8'hFF, 1'b1);
        check("wp5_err", wp_err, 0);
        cpu_write("wp31", 6'd31, 8'h5C, 1'b1);
`endif
        cpu_write("wp50", 6'd50, 8'h3C, 1'b1);

        // Reload from RUN; CPU writes ignored during LOAD; ld_start ignored in LOAD
        start();
        check("reload_rst_n", cpu_rst_n, 0);
        check("reload_ready", ld_ready, 1);
        check("reload_done",  ld_done, 0);
        check("reload_count", ld_count, 0);
        check("reload_wp",    wp_err, 0);
        cpu_write("load_cpu20", 6'd20, 8'hEE, 1'b0);
        send(8'h9A, 1'b0, acc);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("reload_start_ign", ld_count, 1);
        send(8'h9B, 1'b1, acc);
        check("reload_count2", ld_count, 2);
        check("reload_done2",  ld_done, 1);
        cpu_addr = 6'd20;
        #1;
        check("reload_mem20", cpu_rdata, exp_mem[20]);
        tick();
        drain("reload_rd");

        // Reset mid-load: 2 of 5 bytes then clr
        start();
        send(8'hC1, 1'b0, acc);
        send(8'hC2, 1'b0, acc);
        do_clr();
        check("mid_rst_n",  cpu_rst_n, 0);
        check("mid_done",   ld_done, 0);
        check("mid_count",  ld_count, 0);
        check("mid_ready",  ld_ready, 0);
        check("mid_busy",   ld_busy, 0);
        drain("mid_rd");
        send(8'hD0, 1'b1, acc);
        check("idle_valid_ign", acc, 0);
        check("idle_count", ld_count, 0);
        check("idle_state", ld_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
